// File: rtl/test_pe_issue_unq1_pkg.sv
// test_pe_pkg: PE op codes and issue FSM state shared by the PE command driver
package test_pe_pkg;
  localparam logic [5:0] PE_ADD_OP     = 6'h00;
  localparam logic [5:0] PE_SUB_OP     = 6'h01;
  localparam logic [5:0] PE_ABS_OP     = 6'h03;
  localparam logic [5:0] PE_GTE_MAX_OP = 6'h04;
  localparam logic [5:0] PE_LTE_MIN_OP = 6'h05;
  localparam logic [5:0] PE_EQ_OP      = 6'h06;
  localparam logic [5:0] PE_SEL_OP     = 6'h08;
  localparam logic [5:0] PE_MULT_0_OP  = 6'h0B;
  localparam logic [5:0] PE_MULT_1_OP  = 6'h0C;
  localparam logic [5:0] PE_MULT_2_OP  = 6'h0D;
  localparam logic [5:0] PE_RELU_OP    = 6'h0E;
  localparam logic [5:0] PE_RSHFT_OP   = 6'h0F;
  localparam logic [5:0] PE_LSHFT_OP   = 6'h11;
  localparam logic [5:0] PE_OR_OP      = 6'h12;
  localparam logic [5:0] PE_AND_OP     = 6'h13;
  localparam logic [5:0] PE_XOR_OP     = 6'h14;
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} issue_state_e;
endpackage

// File: rtl/test_pe_issue_unq1_if.sv
// test_pe_issue_unq1_if: command and response valid/ready streams of the PE driver
interface test_pe_issue_unq1_if #(parameter int DataWidth = 16);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [8:0]           cmd_op_code;
  logic [DataWidth-1:0] cmd_a;
  logic [DataWidth-1:0] cmd_b;
  logic                 cmd_d_p;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [DataWidth-1:0] rsp_res;
  logic                 rsp_res_p;
  logic [5:0]           rsp_op;
  modport master (
    output cmd_valid, cmd_op_code, cmd_a, cmd_b, cmd_d_p, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_res, rsp_res_p, rsp_op
  );
  modport slave (
    input  cmd_valid, cmd_op_code, cmd_a, cmd_b, cmd_d_p, rsp_ready,
    output cmd_ready, rsp_valid, rsp_res, rsp_res_p, rsp_op
  );
endinterface

// File: rtl/test_pe_issue_unq1_cmd_fifo.sv
// test_pe_cmd_fifo_unq1: synchronous FIFO with registered occupancy, no write-to-read bypass
module test_pe_cmd_fifo_unq1 #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= push ? wptr + 1'b1 : wptr;
      rptr  <= pop ? rptr + 1'b1 : rptr;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  always_ff @(posedge clk)
    if (push) mem[wptr] <= wdata;
  assign rdata = mem[rptr];
  assign full  = count == (AW + 1)'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/test_pe_issue_unq1.sv
// test_pe_issue_unq1: queues PE ops, drives them one at a time onto the PE and
// returns each captured result on the response stream in command order.
module test_pe_issue_unq1
  import test_pe_pkg::*;
#(
  parameter int DataWidth = 16,
  parameter int Depth     = 4,
  parameter int PeLatency = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  test_pe_issue_unq1_if.slave       bus,
  output logic [8:0]                pe_op_code,
  output logic [DataWidth-1:0]      pe_op_a,
  output logic [DataWidth-1:0]      pe_op_b,
  output logic                      pe_op_d_p,
  input  logic [DataWidth-1:0]      pe_res,
  input  logic                      pe_res_p,
  output logic                      busy,
  output logic [$clog2(Depth):0]    count
);
  typedef struct packed {
    logic [8:0]           op_code;
    logic [DataWidth-1:0] a;
    logic [DataWidth-1:0] b;
    logic                 d_p;
  } cmd_t;
  cmd_t         wr_cmd;
  cmd_t         rd_cmd;
  issue_state_e state;
  issue_state_e state_nx;
  logic [2:0]   lat_cnt;
  logic         push;
  logic         pop;
  logic         cap;
  logic         done;
  logic         lat_hit;
  logic         full;
  logic         empty;
  assign wr_cmd        = '{op_code: bus.cmd_op_code, a: bus.cmd_a, b: bus.cmd_b, d_p: bus.cmd_d_p};
  assign bus.cmd_ready = !full;
  assign push          = bus.cmd_valid && !full;
  assign done          = bus.rsp_valid && bus.rsp_ready;
  assign lat_hit       = lat_cnt == 3'(PeLatency);
  assign bus.rsp_op    = pe_op_code[5:0];
  assign busy          = state != IDLE || count != '0;
  test_pe_cmd_fifo_unq1 #(.WIDTH($bits(cmd_t)), .DEPTH(Depth)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (wr_cmd),
    .rdata (rd_cmd),
    .count (count),
    .full  (full),
    .empty (empty)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (empty ? IDLE : WAIT) :
               state == WAIT ? (lat_hit ? HOLD : WAIT) :
               !done ? HOLD : empty ? IDLE : WAIT;
  // A completing handshake in HOLD may reissue the next queued op in the same cycle
  always_comb begin
    pop = !empty && (state == IDLE || (state == HOLD && done));
    cap = state == WAIT && lat_hit;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pe_op_code    <= '0;
      pe_op_a       <= '0;
      pe_op_b       <= '0;
      pe_op_d_p     <= 1'b0;
      lat_cnt       <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_res   <= '0;
      bus.rsp_res_p <= 1'b0;
    end else begin
      if (pop) {pe_op_code, pe_op_a, pe_op_b, pe_op_d_p} <= rd_cmd;
      lat_cnt <= pop ? '0 : (state == WAIT && !lat_hit) ? lat_cnt + 1'b1 : lat_cnt;
      bus.rsp_valid <= cap ? 1'b1 : done ? 1'b0 : bus.rsp_valid;
      if (cap) begin
        bus.rsp_res   <= pe_res;
        bus.rsp_res_p <= pe_res_p;
      end
    end
endmodule
